// File: rtl/param_wave_gen.sv
// Programmable waveform generator: a reloadable prescaler advances a phase
// counter that indexes one of several waveform shapes, with output attenuation.
module param_wave_gen #(
    parameter int W  = 8,
    parameter int PW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic [PW-1:0] PI,
    input  logic [2:0]    Sel,
    input  logic [1:0]    AmpSel,
    input  logic [W-1:0]  Duty,
    output logic [W-1:0]  WaveOut,
    output logic [W-1:0]  AmpWave,
    output logic          Tick,
    output logic          Wrap
);

    logic          running;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pi_reg;
    logic [W-1:0]  cnt;
    logic [2:0]    act_sel;
    logic          ovf;
    logic          last;

    function automatic logic [W-1:0] shape(input logic [2:0]   s,
                                           input logic [W-1:0] c,
                                           input logic [W-1:0] duty);
        logic [W-1:0] dbl;
        dbl = c << 1;
        case (s)
            3'b000:  shape = c;
            3'b001:  shape = ~c;
            3'b010:  shape = c[W-1] ? ~dbl : dbl;
            3'b011:  shape = (c < duty) ? {W{1'b1}} : {W{1'b0}};
            3'b100:  shape = {c[W-1:W-2], {(W-2){1'b0}}};
            3'b101:  shape = (c == {W{1'b0}}) ? {W{1'b1}} : {W{1'b0}};
            default: shape = {W{1'b0}};
        endcase
    endfunction

    // init suppresses any overflow that would coincide with it
    assign ovf  = running && !init && (pcnt == {PW{1'b1}});
    assign last = (cnt == {W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            pcnt    <= '0;
            pi_reg  <= '0;
            cnt     <= '0;
            act_sel <= 3'b000;
            WaveOut <= '0;
            Tick    <= 1'b0;
            Wrap    <= 1'b0;
        end else begin
            if (running)
                WaveOut <= shape(act_sel, cnt, Duty);
            if (init) begin
                running <= 1'b1;
                pcnt    <= PI;
                pi_reg  <= PI;
                cnt     <= '0;
                act_sel <= Sel;
                Tick    <= 1'b0;
                Wrap    <= 1'b0;
            end else begin
                Tick <= ovf;
                Wrap <= ovf && last;
                if (running) begin
                    if (ovf) begin
                        pcnt <= pi_reg;
                        cnt  <= cnt + 1'b1;
                        // a new shape only takes over at the start of a period
                        if (last)
                            act_sel <= Sel;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
            end
        end
    end

    assign AmpWave = WaveOut >> AmpSel;

endmodule

// File: tb/tb_param_wave_gen.sv
// Randomized self-checking bench for param_wave_gen (W=8, PW=9) against a
// reference model that derives phase and ticks from the clock count since init.
module tb_param_wave_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [8:0] PI = '0;
    logic [2:0] Sel = '0;
    logic [1:0] AmpSel = '0;
    logic [7:0] Duty = '0;
    logic [7:0] WaveOut;
    logic [7:0] AmpWave;
    logic       Tick;
    logic       Wrap;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: edges since init and prescale period
    bit m_run;
    int m_n, m_N, m_sel, m_wave;
    bit m_tick, m_wrap;

    param_wave_gen #(.W(8), .PW(9)) dut (
        .clk(clk), .rst(rst), .init(init), .PI(PI), .Sel(Sel),
        .AmpSel(AmpSel), .Duty(Duty), .WaveOut(WaveOut), .AmpWave(AmpWave),
        .Tick(Tick), .Wrap(Wrap)
    );

    always #5 clk = ~clk;

    function automatic int ref_wave(input int s, input int c, input int duty);
        case (s)
            0: return c;
            1: return 255 - c;
            2: return (c < 128) ? 2 * c : 255 - 2 * (c - 128);
            3: return (c < duty) ? 255 : 0;
            4: return (c / 64) * 64;
            5: return (c == 0) ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int phase();
        return m_run ? (m_n / m_N) % 256 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("waveout", 32'(WaveOut), 32'(m_wave));
        chk("ampwave", 32'(AmpWave), 32'(m_wave >> AmpSel));
        chk("tick", 32'(Tick), 32'(m_tick));
        chk("wrap", 32'(Wrap), 32'(m_wrap));
    endtask

    task automatic model_reset();
        m_run = 0; m_n = 0; m_N = 1; m_sel = 0; m_wave = 0; m_tick = 0; m_wrap = 0;
    endtask

    // one clock: inputs already driven; model advanced on the edge, checked 1ns later
    task automatic step(input bit do_init);
        int old_c;
        init = do_init;
        @(posedge clk);
        old_c = phase();
        if (!rst) begin
            if (m_run) m_wave = ref_wave(m_sel, old_c, int'(Duty));
            if (do_init) begin
                m_run = 1; m_n = 0; m_N = 512 - int'(PI); m_sel = int'(Sel);
                m_tick = 0; m_wrap = 0;
            end else if (m_run) begin
                m_n++;
                m_tick = (m_n % m_N) == 0;
                m_wrap = m_tick && (phase() == 0);
                if (m_wrap) m_sel = int'(Sel);
            end else begin
                m_tick = 0; m_wrap = 0;
            end
        end
        #1;
        check_all();
        init = 1'b0;
    endtask

    task automatic run(input int n, input bit rnd_amp);
        for (int i = 0; i < n; i++) begin
            if (rnd_amp) AmpSel = 2'($urandom_range(0, 3));
            step(1'b0);
        end
    endtask

    initial begin
        model_reset();
        #50;
        check_all();
        #3 rst = 1'b0;
        run(6, 1'b1);

        // slow ramp, tick every 4 clocks, one wrap per 1024 clocks
        PI = 9'h1FC; Sel = 3'b000; Duty = 8'($urandom);
        step(1'b1);
        run(1100, 1'b1);

        // triangle, tick every clock
        PI = 9'h1FF; Sel = 3'b010;
        step(1'b1);
        run(300, 1'b1);

        // select change mid-period is deferred until the wrap
        Sel = 3'b000;
        step(1'b1);
        run(100, 1'b1);
        Sel = 3'b001;
        run(400, 1'b1);

        // square at several duty levels including both extremes
        Sel = 3'b011; Duty = 8'd64; AmpSel = 2'd0;
        step(1'b1);
        run(260, 1'b0);
        AmpSel = 2'd2;
        run(260, 1'b0);
        Duty = 8'd0;
        run(260, 1'b1);
        Duty = 8'd255;
        run(260, 1'b1);

        // staircase, pulse, and the unused selects, each from a fresh init
        for (int s = 4; s < 8; s++) begin
            Sel = 3'(s);
            step(1'b1);
            run(270, 1'b1);
        end

        // re-init on a would-be overflow clock (tick every 2 clocks)
        PI = 9'h1FE; Sel = 3'b000;
        step(1'b1);
        run(7, 1'b1);
        step(1'b1);
        run(5, 1'b1);

        // asynchronous reset mid-run, then idle until a new init
        PI = 9'h1FF; Sel = 3'b000;
        step(1'b1);
        run(150, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b0);
        #2 rst = 1'b0;
        Sel = 3'b010; PI = 9'h1F0;
        run(20, 1'b1);
        step(1'b1);
        run(40, 1'b1);

        // random mix: live Sel/PI/Duty changes and occasional re-init
        PI = 9'h1FF;
        step(1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) Sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) Duty = 8'($urandom);
            if ($urandom_range(0, 149) == 0) PI = 9'h1FF - 9'($urandom_range(0, 3));
            AmpSel = 2'($urandom_range(0, 3));
            step($urandom_range(0, 399) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_wave_gen.md
PARAM_WAVE_GEN -- requirements
Module: param_wave_gen

Interface
REQ-001 Parameter W, default 8: sample width of WaveOut/AmpWave, legal range 4..16.
REQ-002 Parameter PW, default 9: prescaler width of PI, legal range 2..16.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 init  input  1  synchronous start/restart strobe; loads PI and Sel, clears phase.
REQ-006 PI  input  PW  prescaler preload; division ratio = 2^PW - PI.
REQ-007 Sel  input  3  waveform select; applied per REQ-016.
REQ-008 AmpSel  input  2  amplitude attenuation, right shift by 0..3.
REQ-009 Duty  input  W  square-wave high threshold, sampled live.
REQ-010 WaveOut  output  W  registered full-scale waveform sample.
REQ-011 AmpWave  output  W  WaveOut >> AmpSel, combinational.
REQ-012 Tick  output  1  one-clk pulse on each prescaler overflow.
REQ-013 Wrap  output  1  one-clk pulse on the Tick where phase wraps max -> 0.

Function
REQ-014 Prescaler: pcnt (PW bits) and pi_reg latched from PI on init; when running and pcnt == all-ones, Tick=1 and pcnt <= pi_reg, else pcnt <= pcnt+1; PI=all-ones -> Tick every clk.
REQ-015 running flag: cleared by reset, set by first init; while 0, pcnt/phase frozen, Tick=Wrap=0, WaveOut held 0.
REQ-016 Sel latched into act_sel on init and on every Wrap cycle only; mid-period Sel changes are deferred to next wrap.
REQ-017 Phase counter cnt (W bits) increments by 1 on each Tick, wraps all-ones -> 0; Wrap asserted on the Tick with cnt == all-ones.
REQ-018 PI changes without init take effect at next overflow reload only if init re-pulsed; pi_reg changes only on init.
REQ-019 Waveforms, f(cnt): 000 ramp up = cnt; 001 ramp down = ~cnt; 010 triangle = cnt<<1 if cnt MSB=0 else ~(cnt<<1); 011 square = all-ones if cnt < Duty else 0; 100 staircase = cnt[W-1:W-2] followed by W-2 zeros; 101 pulse = all-ones if cnt == 0 else 0; 110/111 = 0.
REQ-020 WaveOut <= f(cnt, act_sel) every clk while running: WaveOut lags cnt by exactly 1 clk; Duty=0 -> square constant 0; Duty=all-ones -> high except cnt=all-ones.
REQ-021 AmpWave = WaveOut logically shifted right by AmpSel, zero-filled, same cycle, no truncation beyond shift.
REQ-022 init while running: pcnt <= PI, pi_reg <= PI, cnt <= 0, act_sel <= Sel, Tick=Wrap=0 that cycle; overflow checks resume next clk.
REQ-023 init coincident with a would-be overflow: init wins, no Tick emitted.
REQ-024 All arithmetic unsigned, modulo 2^W or 2^PW; no saturation.

Reset
REQ-025 rst=1 asynchronously forces pcnt=0, pi_reg=0, cnt=0, act_sel=000, running=0, WaveOut=0, Tick=0, Wrap=0; AmpWave therefore 0.
REQ-026 After rst deasserts, block stays idle with all outputs 0 until first init.
REQ-027 rst mid-operation discards pending Sel/PI; next init required to restart.

Verification (W=8, PW=9)
REQ-028 rst 50 ns, init 1 clk, PI=9'h1FC, Sel=000 -> Tick every 4 clks, WaveOut ramps 0..255, Wrap once per 1024 clks.
REQ-029 PI=9'h1FF, init -> Tick every clk; Sel=010 -> WaveOut 0,2,4..254,255,253..1, period 256 clks.
REQ-030 Sel 000 -> 001 at cnt=100 -> WaveOut keeps ramping to 255, becomes ~0=255 then descends only after Wrap.
REQ-031 Sel=011, Duty=64, AmpSel=0 -> WaveOut=255 for cnt 0..63, 0 for 64..255; AmpSel=2 -> AmpWave=63 when high.
REQ-032 Sel=000, AmpSel=2, cnt=200 -> WaveOut=200 next clk, AmpWave=50.
REQ-033 rst pulse mid-ramp -> all outputs 0 immediately (asynchronous), remain 0 after release until init; init re-pulsed during run -> cnt restarts at 0, no Tick that cycle.
